// File: rtl/term_pkg.sv
// Shared types and defaults for the termination igniter controller.
package term_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_QUAL  = 3'd1,
    ST_ARM   = 3'd2,
    ST_FIRE  = 3'd3,
    ST_COOL  = 3'd4,
    ST_DONE  = 3'd5,
    ST_FAULT = 3'd6
  } state_t;

  localparam int SHOT_W = 4;

  localparam int DEF_QUAL_CYCLES = 8;
  localparam int DEF_ARM_CYCLES  = 16;
  localparam int DEF_FIRE_CYCLES = 32;
  localparam int DEF_COOL_CYCLES = 64;
  localparam int DEF_MAX_SHOTS   = 3;
  localparam int DEF_CNT_W       = 16;

  // Shot counter stops at all-ones rather than wrapping back to zero.
  function automatic logic [SHOT_W-1:0] sat_inc(input logic [SHOT_W-1:0] v);
    return (v == {SHOT_W{1'b1}}) ? v : v + SHOT_W'(1);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous pin.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/terminate_fire_ctrl.sv
// Termination igniter sequencer: qualify request, arm, fire with retries,
// verify igniter opened, then latch DONE or FAULT until reset.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for synchronised terminate request
// QUAL     | request must stay high QUAL_CYCLES in a row
// ARM      | committed; armed dwell, continuity checked at the end
// FIRE     | igniter driven for FIRE_CYCLES
// COOL     | post-shot dwell, continuity decides done / retry / fault
// DONE     | igniter confirmed open; terminal
// FAULT    | open at arm or still intact after MAX_SHOTS; terminal
module terminate_fire_ctrl
  import term_pkg::*;
#(
  parameter int QUAL_CYCLES = DEF_QUAL_CYCLES,
  parameter int ARM_CYCLES  = DEF_ARM_CYCLES,
  parameter int FIRE_CYCLES = DEF_FIRE_CYCLES,
  parameter int COOL_CYCLES = DEF_COOL_CYCLES,
  parameter int MAX_SHOTS   = DEF_MAX_SHOTS,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              terminate_req,
  input  logic              continuity,
  output logic              armed_out,
  output logic              fire_out,
  output logic              done,
  output logic              fault,
  output logic [SHOT_W-1:0] shot_count
);

  localparam logic [CNT_W-1:0]  QUAL_TC  = CNT_W'(QUAL_CYCLES - 1);
  localparam logic [CNT_W-1:0]  ARM_TC   = CNT_W'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0]  FIRE_TC  = CNT_W'(FIRE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  COOL_TC  = CNT_W'(COOL_CYCLES - 1);
  localparam logic [SHOT_W-1:0] SHOT_MAX = SHOT_W'(MAX_SHOTS);

  logic             req_s;
  logic             cont_s;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  sync2 u_sync_req (
    .clk (clk),
    .rst (rst),
    .d   (terminate_req),
    .q   (req_s)
  );

  sync2 u_sync_cont (
    .clk (clk),
    .rst (rst),
    .d   (continuity),
    .q   (cont_s)
  );

  // The dwell counter restarts from zero on every state change; each state
  // leaves when the counter reaches its own terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      shot_count <= '0;
      armed_out  <= 1'b0;
      fire_out   <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (req_s) begin
            state <= ST_QUAL;
          end
        end

        ST_QUAL: begin
          if (!req_s) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == QUAL_TC) begin
            state     <= ST_ARM;
            cnt       <= '0;
            armed_out <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_ARM: begin
          if (cnt == ARM_TC) begin
            cnt <= '0;
            if (!cont_s) begin
              state     <= ST_FAULT;
              armed_out <= 1'b0;
              fault     <= 1'b1;
            end else begin
              state      <= ST_FIRE;
              fire_out   <= 1'b1;
              shot_count <= sat_inc(shot_count);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_FIRE: begin
          if (cnt == FIRE_TC) begin
            state    <= ST_COOL;
            cnt      <= '0;
            fire_out <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_COOL: begin
          if (cnt == COOL_TC) begin
            cnt <= '0;
            if (!cont_s) begin
              state     <= ST_DONE;
              armed_out <= 1'b0;
              done      <= 1'b1;
            end else if (shot_count < SHOT_MAX) begin
              state      <= ST_FIRE;
              fire_out   <= 1'b1;
              shot_count <= sat_inc(shot_count);
            end else begin
              state     <= ST_FAULT;
              armed_out <= 1'b0;
              fault     <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_DONE: begin
          cnt       <= '0;
          armed_out <= 1'b0;
          fire_out  <= 1'b0;
          done      <= 1'b1;
        end

        ST_FAULT: begin
          cnt       <= '0;
          armed_out <= 1'b0;
          fire_out  <= 1'b0;
          fault     <= 1'b1;
        end

        default: begin
          state     <= ST_IDLE;
          cnt       <= '0;
          armed_out <= 1'b0;
          fire_out  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/terminate_fire_ctrl.md
Name: terminate_fire_ctrl

Overview:
- Downstream stage of the flight StateMachine; consumes its terminatepin output and drives the termination igniter.
- Qualifies the terminate request, arms, fires a fixed-width pulse and checks igniter continuity after each shot.
- Retries up to MAX_SHOTS, then latches DONE or FAULT until reset.
- Single clock domain (50 MHz system clock); inputs are asynchronous pins and are synchronised internally.

Parameters:
- QUAL_CYCLES, 8: consecutive synchronised-high cycles of terminate_req needed to commit.
- ARM_CYCLES, 16: armed dwell before first shot.
- FIRE_CYCLES, 32: fire_out high width per shot.
- COOL_CYCLES, 64: dwell after each shot before the continuity check.
- MAX_SHOTS, 3: maximum shots (1..15).
- CNT_W, 16: dwell counter width; must hold max(QUAL,ARM,FIRE,COOL)_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- terminate_req  in  1  terminatepin from StateMachine; asynchronous.
- continuity  in  1  igniter continuity sense; 1 = igniter intact; asynchronous.
- armed_out  out  1  high from ARM through COOL (retries included).
- fire_out  out  1  igniter drive, registered.
- done  out  1  sticky; igniter confirmed open after a shot.
- fault  out  1  sticky; no continuity at arm, or igniter still intact after MAX_SHOTS.
- shot_count  out  4  shots fired since reset.

Behaviour:
- Reset: every output is 0, state is IDLE, counters are 0, sync flops are 0. Reset asserted mid-FIRE drops fire_out at that same edge.
- Sync: terminate_req and continuity each pass through a 2-flop synchroniser (req_s, cont_s). Only req_s and cont_s are used internally.
- States: IDLE, QUAL, ARM, FIRE, COOL, DONE, FAULT. Encoding lives in the package.
- IDLE: go to QUAL when req_s = 1. The dwell counter clears on every state entry.
- QUAL: req_s = 0 in any cycle returns to IDLE; nothing is armed and shot_count is unchanged. After QUAL_CYCLES consecutive highs, go to ARM.
- ARM: armed_out = 1; dwell ARM_CYCLES. Once in ARM the sequence is committed and req_s is ignored from then on. At the end of the dwell: cont_s = 0 goes to FAULT; otherwise go to FIRE.
- FIRE: fire_out = 1 for exactly FIRE_CYCLES cycles. shot_count increments by 1 on entry and saturates at 15. Then go to COOL.
- COOL: fire_out = 0, armed_out = 1; dwell COOL_CYCLES, then sample cont_s:
  - cont_s = 0: go to DONE.
  - cont_s = 1 and shot_count < MAX_SHOTS: go to FIRE (retry).
  - cont_s = 1 and shot_count = MAX_SHOTS: go to FAULT.
- DONE / FAULT: terminal until rst. armed_out = 0, fire_out = 0, flag held at 1. All inputs are ignored.
- Latency: fire_out first rises 2 + QUAL_CYCLES + ARM_CYCLES edges after the first edge that samples terminate_req = 1. With defaults this is 26.
- Continuity changes during FIRE or ARM dwell have no effect; only the end-of-dwell sample counts.
- terminate_req re-asserting after DONE or FAULT has no effect.

Decomposition:
- Package term_pkg: state enum; the width of shot_count (4); default parameter constants.
- One sub-module, sync2, instantiated twice (for terminate_req and continuity).
- Top level holds the FSM, a single shared dwell counter and shot_count.

Test Plan:
- Nominal: continuity = 1; terminate_req rises at cycle 0 and stays high; continuity drops at cycle 60 (mid-COOL) → fire_out high for cycles 26..57; done = 1 at COOL end; shot_count = 1; fault = 0.
- Glitch rejection: terminate_req high for 5 cycles, then low → fire_out and armed_out stay 0; state returns to IDLE; shot_count = 0.
- Open igniter at arm: continuity = 0 throughout; terminate_req held → armed_out pulses for 16 cycles; fault = 1; fire_out never asserts.
- Retry exhaustion: continuity stuck at 1 → exactly 3 fire_out pulses, each 32 cycles, separated by 64-cycle gaps; shot_count = 3; fault = 1.
- Second-shot success: continuity drops during the second COOL → 2 pulses; done = 1; shot_count = 2.
- Reset mid-fire: rst asserted on cycle 10 of the first FIRE → fire_out = 0 on the next edge; all outputs 0; with terminate_req still held, the full sequence restarts and fire_out rises again 26 edges after rst deasserts.
